// File: rtl/request_fifo_if.sv
// rtl/request_fifo_if.sv - request FIFO push/pop/status bundle
// The producer/consumer side uses master; the FIFO uses slave.
interface request_fifo_if #(
    parameter int TID_WIDTH  = 16,
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
);
    localparam int W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;

    logic                  wr_en;
    logic [W-1:0]          data_in;
    logic                  full;
    logic                  rd_en;
    logic [W-1:0]          data_out;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   max_count;

    modport master (
        output wr_en, data_in, rd_en,
        input  full, data_out, empty, overflow, underflow, count, max_count
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output full, data_out, empty, overflow, underflow, count, max_count
    );
endinterface

// File: rtl/request_fifo.sv
// rtl/request_fifo.sv - synchronous request FIFO with registered head and sticky error flags
// Optional occupancy statistics enabled by defining REQUEST_FIFO_STATS_EN.
module request_fifo #(
    parameter int TID_WIDTH  = 16,
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    request_fifo_if.slave bus
);
    localparam int W     = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]        r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic                r_full;
    logic                r_empty;
    logic [W-1:0]        r_data_out;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [DEPTH_LOG2:0] w_wptr_nxt;
    logic [DEPTH_LOG2:0] w_rptr_nxt;
    logic                w_full_nxt;
    logic                w_empty_nxt;

    assign w_wr_acc   = bus.wr_en && !r_full;
    assign w_rd_acc   = bus.rd_en && !r_empty;
    assign w_wptr_nxt = r_wptr + {{DEPTH_LOG2{1'b0}}, w_wr_acc};
    assign w_rptr_nxt = r_rptr + {{DEPTH_LOG2{1'b0}}, w_rd_acc};

    // Flags come from next-state pointers so they are registered yet never stale.
    assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
    assign w_full_nxt  = (w_wptr_nxt[DEPTH_LOG2] != w_rptr_nxt[DEPTH_LOG2]) &&
                         (w_wptr_nxt[DEPTH_LOG2-1:0] == w_rptr_nxt[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
            end
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.data_out  = r_data_out;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef REQUEST_FIFO_STATS_EN
    logic [DEPTH_LOG2:0] r_count;
    logic [DEPTH_LOG2:0] r_max_count;
    logic [DEPTH_LOG2:0] w_count_nxt;

    assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_max_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_count_nxt > r_max_count) begin
                r_max_count <= w_count_nxt;
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.max_count = r_max_count;
`else
    assign bus.count     = '0;
    assign bus.max_count = '0;
`endif
endmodule

// File: tb/tb_request_fifo.sv
// tb/tb_request_fifo.sv - directed self-checking bench for request_fifo
// Count/max_count expectations follow REQUEST_FIFO_STATS_EN.
module tb_request_fifo;
    localparam int W = 80;
`ifdef REQUEST_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   compared;
    int   failed;

    request_fifo_if bus ();

    request_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] ent(input int tid);
        logic [15:0] t;
        logic [30:0] a;
        logic [31:0] d;
        t = tid[15:0];
        a = 31'(tid) * 31'd7 + 31'd3;
        d = 32'hA5A5_0000 ^ 32'(tid);
        return {t, t[0], a, d};
    endfunction

    function automatic logic [4:0] exp_cnt(input int n);
        return STATS ? 5'(n) : 5'd0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tid);
        bus.wr_en   = 1'b1;
        bus.data_in = ent(tid);
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
        reset = 1'b0;
        #12;
        compared++; if (bus.empty !== 1'b1) begin failed++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        compared++; if (bus.full !== 1'b0) begin failed++; $display("FAIL reset_full: got %b want 0", bus.full); end
        compared++; if (bus.data_out !== '0) begin failed++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failed++; $display("FAIL reset_flags: got %b want 00", {bus.overflow, bus.underflow}); end
        compared++; if ({bus.count, bus.max_count} !== 10'd0) begin failed++; $display("FAIL reset_stats: got %h want 0", {bus.count, bus.max_count}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push(i);
            if (i == 15) begin
                compared++; if (bus.full !== 1'b0) begin failed++; $display("FAIL fill_full_at_15: got %b want 0", bus.full); end
            end
        end
        compared++; if (bus.full !== 1'b1) begin failed++; $display("FAIL fill_full: got %b want 1", bus.full); end
        compared++; if (bus.empty !== 1'b0) begin failed++; $display("FAIL fill_empty: got %b want 0", bus.empty); end
        compared++; if (bus.count !== exp_cnt(16)) begin failed++; $display("FAIL fill_count: got %0d want %0d", bus.count, exp_cnt(16)); end
    endtask

    task automatic test_overflow_drain();
        compared++; if (bus.overflow !== 1'b0) begin failed++; $display("FAIL ovf_before: got %b want 0", bus.overflow); end
        push(17);
        compared++; if (bus.overflow !== 1'b1) begin failed++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        compared++; if (bus.count !== exp_cnt(16)) begin failed++; $display("FAIL ovf_count: got %0d want %0d", bus.count, exp_cnt(16)); end
        for (int i = 1; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            cycle();
            compared++; if (bus.data_out !== ent(i)) begin failed++; $display("FAIL drain_order[%0d]: got %h want %h", i, bus.data_out, ent(i)); end
        end
        bus.rd_en = 1'b0;
        compared++; if (bus.empty !== 1'b1) begin failed++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        compared++; if (bus.max_count !== exp_cnt(16)) begin failed++; $display("FAIL drain_max_count: got %0d want %0d", bus.max_count, exp_cnt(16)); end
    endtask

    task automatic test_underflow();
        compared++; if (bus.underflow !== 1'b0) begin failed++; $display("FAIL unf_before: got %b want 0", bus.underflow); end
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        compared++; if (bus.underflow !== 1'b1) begin failed++; $display("FAIL unf_set: got %b want 1", bus.underflow); end
        compared++; if (bus.data_out !== ent(16)) begin failed++; $display("FAIL unf_data_hold: got %h want %h", bus.data_out, ent(16)); end
        compared++; if (bus.empty !== 1'b1) begin failed++; $display("FAIL unf_empty: got %b want 1", bus.empty); end
        cycle();
        compared++; if (bus.underflow !== 1'b1) begin failed++; $display("FAIL unf_sticky: got %b want 1", bus.underflow); end
    endtask

    task automatic test_no_bypass();
        do_reset();
        cycle();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = ent(50);
        cycle();
        bus.wr_en = 1'b0;
        compared++; if (bus.data_out !== '0) begin failed++; $display("FAIL nobypass_data: got %h want 0", bus.data_out); end
        compared++; if (bus.empty !== 1'b0) begin failed++; $display("FAIL nobypass_empty: got %b want 0", bus.empty); end
        compared++; if (bus.underflow !== 1'b1) begin failed++; $display("FAIL nobypass_unf: got %b want 1", bus.underflow); end
        cycle();
        bus.rd_en = 1'b0;
        compared++; if (bus.data_out !== ent(50)) begin failed++; $display("FAIL nobypass_read: got %h want %h", bus.data_out, ent(50)); end
        compared++; if (bus.empty !== 1'b1) begin failed++; $display("FAIL nobypass_empty_after: got %b want 1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) push(100 + i);
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = ent(108 + i);
            cycle();
            compared++; if (bus.data_out !== ent(100 + i)) begin failed++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.data_out, ent(100 + i)); end
            compared++; if (bus.count !== exp_cnt(8)) begin failed++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, bus.count, exp_cnt(8)); end
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        compared++; if (bus.max_count !== exp_cnt(8)) begin failed++; $display("FAIL b2b_max_count: got %0d want %0d", bus.max_count, exp_cnt(8)); end
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1'b1;
            cycle();
            compared++; if (bus.data_out !== ent(120 + i)) begin failed++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, bus.data_out, ent(120 + i)); end
        end
        bus.rd_en = 1'b0;
        compared++; if ({bus.empty, bus.overflow, bus.underflow} !== 3'b100) begin failed++; $display("FAIL b2b_final_flags: got %b want 100", {bus.empty, bus.overflow, bus.underflow}); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 1; i <= 16; i++) push(i);
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = ent(99);
        cycle();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        compared++; if (bus.data_out !== ent(1)) begin failed++; $display("FAIL fullrw_head: got %h want %h", bus.data_out, ent(1)); end
        compared++; if (bus.overflow !== 1'b1) begin failed++; $display("FAIL fullrw_ovf: got %b want 1", bus.overflow); end
        compared++; if (bus.full !== 1'b0) begin failed++; $display("FAIL fullrw_full: got %b want 0", bus.full); end
        compared++; if (bus.count !== exp_cnt(15)) begin failed++; $display("FAIL fullrw_count: got %0d want %0d", bus.count, exp_cnt(15)); end
        for (int i = 2; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            cycle();
            compared++; if (bus.data_out !== ent(i)) begin failed++; $display("FAIL fullrw_drain[%0d]: got %h want %h", i, bus.data_out, ent(i)); end
        end
        bus.rd_en = 1'b0;
        compared++; if (bus.empty !== 1'b1) begin failed++; $display("FAIL fullrw_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        for (int i = 0; i < 5; i++) push(200 + i);
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        compared++; if (bus.data_out !== ent(200)) begin failed++; $display("FAIL async_pre_data: got %h want %h", bus.data_out, ent(200)); end
        #3;
        reset = 1'b0;
        #1;
        compared++; if ({bus.empty, bus.full} !== 2'b10) begin failed++; $display("FAIL async_empty_full: got %b want 10", {bus.empty, bus.full}); end
        compared++; if (bus.data_out !== '0) begin failed++; $display("FAIL async_data_out: got %h want 0", bus.data_out); end
        compared++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failed++; $display("FAIL async_flags: got %b want 00", {bus.overflow, bus.underflow}); end
        compared++; if ({bus.count, bus.max_count} !== 10'd0) begin failed++; $display("FAIL async_stats: got %h want 0", {bus.count, bus.max_count}); end
        #2;
        reset = 1'b1;
        push(60);
        compared++; if (bus.empty !== 1'b0) begin failed++; $display("FAIL async_first_write: got empty=%b want 0", bus.empty); end
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        compared++; if (bus.data_out !== ent(60)) begin failed++; $display("FAIL async_discarded: got %h want %h", bus.data_out, ent(60)); end
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_no_bypass();
        test_back_to_back();
        test_full_rw();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
